// File: rtl/truth_table_sweeper_if.sv
// Control and function-bus signals of the truth-table sweeper.
// master: the test/control side together with the two function instances.
// slave:  the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            abort;
  logic            res_a;
  logic            res_b;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    output start, abort, res_a, res_b,
    input  vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, abort, res_a, res_b,
    output vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to two
// implementations of one Boolean function, waits SETTLE cycles per vector,
// then compares their outputs and reports count, first failure and pass.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t          state;
  logic [3:0]      cnt;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic            fv_q;
  logic [N_IN-1:0] ffv_q;
  logic            mismatch;

  assign mismatch = bus.res_a ^ bus.res_b;

  // Sweep sequencer: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      ffv_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            vec_q  <= '0;
            err_q  <= '0;
            fv_q   <= 1'b0;
            ffv_q  <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= SETTLE_W;
            state  <= (SETTLE == 0) ? S_COMPARE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            vec_q  <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt <= 4'd1) begin
            state <= S_COMPARE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_COMPARE: begin
          if (bus.abort) begin
            vec_q  <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if (mismatch) begin
              err_q <= err_q + 1'b1;
              if (!fv_q) begin
                fv_q  <= 1'b1;
                ffv_q <= vec_q;
              end
            end
            if (vec_q == '1) begin
              // pass is resolved together with done so it already reflects
              // the result of this last compare during the done pulse.
              pass_q <= (err_q == '0) && !mismatch;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end else begin
              vec_q <= vec_q + 1'b1;
              cnt   <= SETTLE_W;
              state <= (SETTLE == 0) ? S_COMPARE : S_WAIT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (SETTLE=1 and
// SETTLE=0) share clock and reset; expected sweep results are queued at
// start and popped by per-instance monitors on each done pulse.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  int unsigned mode0;
  int unsigned mode1;

  typedef struct {
    int unsigned errs;
    int unsigned fv;
    int unsigned ffv;
    int unsigned pass;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0e;
  exp_t m1e;

  truth_table_sweeper_if #(.N_IN(2)) if0 ();
  truth_table_sweeper_if #(.N_IN(2)) if1 ();

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Function instances: A is always AND; B is AND, NAND, or AND flipped at 2'b10.
  function automatic logic fb(input int unsigned mode, input logic [1:0] v);
    case (mode)
      1:       return ~&v;
      2:       return (&v) ^ (v == 2'b10);
      default: return &v;
    endcase
  endfunction

  always_comb begin
    if0.res_a = &if0.vec_out;
    if0.res_b = fb(mode0, if0.vec_out);
    if1.res_a = &if1.vec_out;
    if1.res_b = fb(mode1, if1.vec_out);
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if0.done) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_done", 1, 0);
      end else begin
        m0e = q0.pop_front();
        chk("u0_err_count", 32'(if0.err_count), m0e.errs);
        chk("u0_fail_valid", 32'(if0.fail_valid), m0e.fv);
        chk("u0_first_fail_vec", 32'(if0.first_fail_vec), m0e.ffv);
        chk("u0_pass", 32'(if0.pass), m0e.pass);
        chk("u0_latency", cyc - m0e.t0, m0e.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.done) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        m1e = q1.pop_front();
        chk("u1_err_count", 32'(if1.err_count), m1e.errs);
        chk("u1_fail_valid", 32'(if1.fail_valid), m1e.fv);
        chk("u1_first_fail_vec", 32'(if1.first_fail_vec), m1e.ffv);
        chk("u1_pass", 32'(if1.pass), m1e.pass);
        chk("u1_latency", cyc - m1e.t0, m1e.lat);
      end
    end
  end

  function automatic exp_t mk(input int unsigned errs, input int unsigned fv,
                              input int unsigned ffv, input int unsigned pass,
                              input int unsigned lat);
    exp_t e;
    e.errs = errs; e.fv = fv; e.ffv = ffv; e.pass = pass; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Pulse start so it is sampled at one edge; returns 1 ns after that edge.
  task automatic go0(input exp_t e, input bit push);
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    e.t0 = cyc;
    if (push) q0.push_back(e);
  endtask

  task automatic go1(input exp_t e, input bit push);
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    e.t0 = cyc;
    if (push) q1.push_back(e);
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !if0.busy && !if1.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_vec0(input string nm, input logic [1:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if0.vec_out == v) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic chk_zero0(input string nm);
    chk({nm, "_vec_out"}, 32'(if0.vec_out), 0);
    chk({nm, "_busy"}, 32'(if0.busy), 0);
    chk({nm, "_done"}, 32'(if0.done), 0);
    chk({nm, "_pass"}, 32'(if0.pass), 0);
    chk({nm, "_err_count"}, 32'(if0.err_count), 0);
    chk({nm, "_fail_valid"}, 32'(if0.fail_valid), 0);
    chk({nm, "_first_fail_vec"}, 32'(if0.first_fail_vec), 0);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; mode0 = 0; mode1 = 0;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0;
    #1;
    chk_zero0("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: identical implementations
    mode0 = 0;
    go0(mk(0, 0, 0, 1, 8), 1'b1);
    drain("t1_drain");

    // 2: AND vs NAND, every vector fails
    mode0 = 1;
    go0(mk(4, 1, 0, 0, 8), 1'b1);
    drain("t2_drain");

    // 3: single failure at 2'b10
    mode0 = 2;
    go0(mk(1, 1, 2, 0, 8), 1'b1);
    drain("t3_drain");

    // 4: SETTLE=0, vec_out advances each cycle, start during busy ignored
    mode1 = 1;
    go1(mk(4, 1, 0, 0, 4), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_vec_step", 32'(if1.vec_out), i);
      if (i == 1) if1.start = 1'b1;
      @(posedge clk);
      #1;
      if1.start = 1'b0;
    end
    drain("t4_drain");

    // 5: abort while vec_out=01; partial results retained, no done
    mode0 = 1;
    go0(mk(0, 0, 0, 0, 0), 1'b0);
    wait_vec0("t5_wait_vec1", 2'b01);
    if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.abort = 1'b0;
    chk("t5_busy", 32'(if0.busy), 0);
    chk("t5_vec_out", 32'(if0.vec_out), 0);
    chk("t5_pass", 32'(if0.pass), 0);
    chk("t5_err_kept", 32'(if0.err_count), 1);
    chk("t5_fv_kept", 32'(if0.fail_valid), 1);
    repeat (12) @(negedge clk);
    chk("t5_still_idle", 32'(if0.busy), 0);
    mode0 = 0;
    go0(mk(0, 0, 0, 1, 8), 1'b1);
    chk("t5_err_cleared", 32'(if0.err_count), 0);
    chk("t5_fv_cleared", 32'(if0.fail_valid), 0);
    drain("t5_drain");

    // 6: asynchronous reset mid-sweep
    mode0 = 1;
    go0(mk(0, 0, 0, 0, 0), 1'b0);
    wait_vec0("t6_wait_vec2", 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero0("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_idle_busy", 32'(if0.busy), 0);
    chk("t6_idle_vec", 32'(if0.vec_out), 0);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
